// File: rtl/opll_bus_write_sequencer_if.sv
// Host/bus bundle for opll_bus_write_sequencer: write handshake on the host side,
// YM2413-style CS_n/WR_n/A0/D pins toward the OPLL core.
`timescale 1ns/1ps
interface opll_bus_write_sequencer_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic          i_wr_valid;
  logic [7:0]    i_wr_addr;
  logic [7:0]    i_wr_data;
  logic          o_wr_ready;
  logic          o_CS_n;
  logic          o_WR_n;
  logic          o_A0;
  logic [7:0]    o_D;
  logic          o_busy;
  logic [LW-1:0] o_level;

  // master: the host issuing writes and observing the bus
  modport master (
    output i_wr_valid, i_wr_addr, i_wr_data,
    input  o_wr_ready, o_CS_n, o_WR_n, o_A0, o_D, o_busy, o_level
  );

  // slave: the sequencer itself
  modport slave (
    input  i_wr_valid, i_wr_addr, i_wr_data,
    output o_wr_ready, o_CS_n, o_WR_n, o_A0, o_D, o_busy, o_level
  );
endinterface

// File: rtl/opll_bus_write_sequencer.sv
// FIFO-buffered OPLL register write sequencer: replays (addr, data) as an address
// then data bus cycle with post-write waits. Optional: OPLL_WRSEQ_SKIP_ADDR_EN.
`timescale 1ns/1ps
module opll_bus_write_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PULSE_LEN  = 4,
  parameter int unsigned ADDR_WAIT  = 12,
  parameter int unsigned DATA_WAIT  = 84
) (
  input  logic                        clk,
  input  logic                        rst_n,
  opll_bus_write_sequencer_if.slave   bus
);

  localparam int unsigned PW      = $clog2(FIFO_DEPTH);
  localparam int unsigned LW      = PW + 1;
  localparam int unsigned MAX_PA  = (PULSE_LEN > ADDR_WAIT) ? PULSE_LEN : ADDR_WAIT;
  localparam int unsigned CNT_MAX = (MAX_PA > DATA_WAIT) ? MAX_PA : DATA_WAIT;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] AWAIT_LOAD = CW'(ADDR_WAIT - 1);
  localparam logic [CW-1:0] DWAIT_LOAD = CW'(DATA_WAIT - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] A_PULSE = 3'd1;
  localparam logic [2:0] A_WAIT  = 3'd2;
  localparam logic [2:0] D_PULSE = 3'd3;
  localparam logic [2:0] D_WAIT  = 3'd4;

  // FIFO storage: {addr, data}
  logic [15:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          strobe_n;
  logic          a0_q;
  logic [7:0]    d_q;
  logic [7:0]    cur_data;

  logic          full;
  logic          not_empty;
  logic          push;
  logic          pop;
  logic [7:0]    head_addr;
  logic [7:0]    head_data;
  logic          skip_a;

  always_comb begin
    full      = (level == LW'(FIFO_DEPTH));
    not_empty = (level != '0);
    push      = bus.i_wr_valid && !full;
    pop       = not_empty &&
                ((state == IDLE) || ((state == D_WAIT) && (cnt == '0)));
    head_addr = mem[rd_ptr][15:8];
    head_data = mem[rd_ptr][7:0];
  end

`ifdef OPLL_WRSEQ_SKIP_ADDR_EN
  logic [7:0] last_addr;
  logic       last_addr_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr       <= '0;
      last_addr_valid <= 1'b0;
    end else if (pop) begin
      last_addr       <= head_addr;
      last_addr_valid <= 1'b1;
    end
  end

  always_comb begin
    skip_a = last_addr_valid && (head_addr == last_addr);
  end
`else
  always_comb begin
    skip_a = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.i_wr_addr, bus.i_wr_data};
    end
  end

  // Pointers wrap naturally: FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      strobe_n <= 1'b1;
      a0_q     <= 1'b0;
      d_q      <= '0;
      cur_data <= '0;
    end else begin
      case (state)
        IDLE, D_WAIT: begin
          if ((state == D_WAIT) && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
          end else if (pop) begin
            // A repeated address (skip build only) jumps straight to the data phase.
            cur_data <= head_data;
            strobe_n <= 1'b0;
            cnt      <= PULSE_LOAD;
            if (skip_a) begin
              state <= D_PULSE;
              a0_q  <= 1'b1;
              d_q   <= head_data;
            end else begin
              state <= A_PULSE;
              a0_q  <= 1'b0;
              d_q   <= head_addr;
            end
          end else begin
            state <= IDLE;
          end
        end
        A_PULSE: begin
          if (cnt == '0) begin
            state    <= A_WAIT;
            strobe_n <= 1'b1;
            cnt      <= AWAIT_LOAD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        A_WAIT: begin
          if (cnt == '0) begin
            state    <= D_PULSE;
            a0_q     <= 1'b1;
            d_q      <= cur_data;
            strobe_n <= 1'b0;
            cnt      <= PULSE_LOAD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        D_PULSE: begin
          if (cnt == '0) begin
            state    <= D_WAIT;
            strobe_n <= 1'b1;
            cnt      <= DWAIT_LOAD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          strobe_n <= 1'b1;
          cnt      <= '0;
        end
      endcase
    end
  end

  assign bus.o_wr_ready = !full;
  assign bus.o_CS_n     = strobe_n;
  assign bus.o_WR_n     = strobe_n;
  assign bus.o_A0       = a0_q;
  assign bus.o_D        = d_q;
  assign bus.o_busy     = (state != IDLE) || not_empty;
  assign bus.o_level    = level;

endmodule
